// File: rtl/imem_loader.sv
// Serial byte-stream loader that fills instruction memory word by word.
// Bytes assemble big-endian; the CPU is held while busy is high.
module imem_loader #(
  parameter int WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  word_count,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] MAXW = 5'(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  n;
  logic [4:0]  n_clamp;
  logic [1:0]  byte_cnt;
  logic [4:0]  word_idx;
  logic [31:0] word;
  logic        xfer;
  logic        last;

  assign n_clamp = (word_count > MAXW) ? MAXW : word_count;
  assign xfer    = in_valid & in_ready;
  assign last    = (word_idx == n - 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start) state_nx = (n_clamp == 5'd0) ? DONE : LOAD;
      LOAD:
        if (abort)                         state_nx = IDLE;
        else if (xfer && byte_cnt == 2'd3) state_nx = WRITE;
      WRITE:
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
        else           state_nx = LOAD;
      DONE:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      // abort withdraws ready so a simultaneous byte stays with the source
      LOAD:  in_ready = ~abort;
      WRITE: begin
        mem_we    = ~abort;
        mem_addr  = {word_idx[3:0], 2'b00};
        mem_wdata = word;
      end
      DONE:  done = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      word     <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (start) begin
            n        <= n_clamp;
            byte_cnt <= '0;
            word_idx <= '0;
            word     <= '0;
          end
        LOAD:
          if (abort) begin
            byte_cnt <= '0;
            word     <= '0;
          end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= {word[23:0], in_data};
          end
        WRITE:
          if (abort) begin
            byte_cnt <= '0;
            word     <= '0;
          end else begin
            word_idx <= word_idx + 5'd1;
          end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table plus
// hand-written gap, clamp, abort and async-reset sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  word_count = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int          done_cnt = 0;

  imem_loader #(.WORDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (rst_n && done) done_cnt++;
  end

  typedef struct {
    logic        st;
    logic [4:0]  wc;
    logic        ab;
    logic        iv;
    logic [7:0]  id;
    logic        rdy;
    logic        we;
    logic [5:0]  ad;
    logic [31:0] wdat;
    logic        bz;
    logic        dn;
  } vec_t;

  vec_t vec[16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [4:0] wc);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // present a byte until the loader takes it; returns at posedge+1
  task automatic put(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL put_timeout byte %h never accepted", b);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy still %b", busy);
    end
  endtask

  task automatic check_writes(input string name, input int exp_n);
    chk({name, "_nwrites"}, 64'(wa.size()), 64'(exp_n));
  endtask

  initial begin
    logic [7:0]  s2[8];
    logic [31:0] ew;

    vec[0]  = '{1, 5'd2, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 0, 0};
    vec[1]  = '{0, 5'd0, 0, 1, 8'h20, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[2]  = '{1, 5'd7, 0, 1, 8'h08, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[3]  = '{0, 5'd0, 0, 1, 8'h00, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[4]  = '{0, 5'd0, 0, 1, 8'h17, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[5]  = '{0, 5'd0, 0, 0, 8'h00, 0, 1, 6'h00, 32'h20080017, 1, 0};
    vec[6]  = '{0, 5'd0, 0, 1, 8'h21, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[7]  = '{0, 5'd0, 0, 1, 8'h09, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[8]  = '{0, 5'd0, 0, 1, 8'h00, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[9]  = '{0, 5'd0, 0, 1, 8'h2d, 1, 0, 6'h00, 32'h0, 1, 0};
    vec[10] = '{0, 5'd0, 0, 0, 8'h00, 0, 1, 6'h04, 32'h2109002d, 1, 0};
    vec[11] = '{0, 5'd0, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 1, 1};
    vec[12] = '{0, 5'd0, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 0, 0};
    vec[13] = '{1, 5'd0, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 0, 0};
    vec[14] = '{0, 5'd0, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 1, 1};
    vec[15] = '{0, 5'd0, 0, 0, 8'h00, 0, 0, 6'h00, 32'h0, 0, 0};

    s2[0] = 8'h20; s2[1] = 8'h08; s2[2] = 8'h00; s2[3] = 8'h17;
    s2[4] = 8'h21; s2[5] = 8'h09; s2[6] = 8'h00; s2[7] = 8'h2d;

    // reset state
    #12;
    chk("reset_outs",
        64'({in_ready, mem_we, mem_addr, mem_wdata, busy, done}), 64'h0);
    #5 rst_n = 1'b1;

    // vector table: two-word load, start-while-busy, zero count
    foreach (vec[i]) begin
      @(posedge clk); #1;
      start      = vec[i].st;
      word_count = vec[i].wc;
      abort      = vec[i].ab;
      in_valid   = vec[i].iv;
      in_data    = vec[i].id;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({in_ready, mem_we, mem_addr, mem_wdata, busy, done}),
          64'({vec[i].rdy, vec[i].we, vec[i].ad, vec[i].wdat,
               vec[i].bz, vec[i].dn}));
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    check_writes("table", 2);
    chk("table_dones", 64'(done_cnt), 64'd2);

    // stream gaps
    clear_log();
    do_start(5'd2);
    for (int i = 0; i < 8; i++) begin
      put(s2[i]);
      @(negedge clk);
      chk($sformatf("gap_ready%0d", i), 64'(in_ready), 64'(i % 4 != 3));
      @(posedge clk); #1;
    end
    wait_idle();
    check_writes("gap", 2);
    if (wa.size() == 2) begin
      chk("gap_w0", 64'({wa[0], wd[0]}), 64'({6'h00, 32'h20080017}));
      chk("gap_w1", 64'({wa[1], wd[1]}), 64'({6'h04, 32'h2109002d}));
    end
    chk("gap_done", 64'(done_cnt), 64'd1);

    // clamp: 20 requested, 16 loaded
    clear_log();
    do_start(5'd20);
    for (int i = 0; i < 64; i++) put(8'(i));
    wait_idle();
    check_writes("clamp", 16);
    for (int k = 0; k < 16 && k < wa.size(); k++) begin
      ew = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      chk($sformatf("clamp_w%0d", k), 64'({wa[k], wd[k]}),
          64'({6'(4*k), ew}));
    end
    chk("clamp_done", 64'(done_cnt), 64'd1);
    in_valid = 1'b1;
    in_data = 8'h99;
    repeat (3) @(negedge clk);
    chk("clamp_no_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check_writes("clamp_after", 16);

    // abort during word 1 of a 3-word load
    clear_log();
    do_start(5'd3);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h55); put(8'h66);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    @(negedge clk);
    chk("abort_ready", 64'({in_ready, mem_we}), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'({busy, in_ready}), 64'd0);
    repeat (4) @(negedge clk);
    check_writes("abort", 1);
    if (wa.size() == 1)
      chk("abort_w0", 64'({wa[0], wd[0]}), 64'({6'h00, 32'h11223344}));
    chk("abort_nodone", 64'(done_cnt), 64'd0);
    clear_log();
    do_start(5'd1);
    put(8'haa); put(8'hbb); put(8'hcc); put(8'hdd);
    wait_idle();
    check_writes("reload", 1);
    if (wa.size() == 1)
      chk("reload_w0", 64'({wa[0], wd[0]}), 64'({6'h00, 32'haabbccdd}));
    chk("reload_done", 64'(done_cnt), 64'd1);

    // async reset mid-load
    clear_log();
    do_start(5'd2);
    put(8'h01); put(8'h02);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs",
        64'({in_ready, mem_we, mem_addr, mem_wdata, busy, done}), 64'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 8'h03;
    repeat (8) @(negedge clk);
    chk("arst_idle", 64'({busy, in_ready}), 64'd0);
    in_valid = 1'b0;
    check_writes("arst", 0);
    chk("arst_nodone", 64'(done_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
